// File: rtl/sqrt16.sv
// Sequential restoring integer square root: floor(sqrt(x)) and remainder,
// one root bit per clock, start/ready handshake matching the shift-add multiplier.
module sqrt16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] x_bi,
  input  logic        start_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [7:0]  y_bo,
  output logic [8:0]  rem_bo
);

  typedef enum logic [1:0] {IDLE, WORK, READY} state_t;

  state_t      state;
  logic [15:0] x_r;
  logic [15:0] root_r;
  logic [15:0] mask_r;
  logic [2:0]  cnt_r;

  logic [15:0] trial;
  logic        fits;
  logic [15:0] x_next;
  logic [15:0] root_next;

  assign busy_o  = (state == WORK);
  assign ready_o = (state == READY);

  // root_r holds the partial root pre-shifted so that root|mask forms the trial subtrahend
  always_comb begin
    trial     = root_r | mask_r;
    fits      = (x_r >= trial);
    x_next    = x_r;
    root_next = root_r >> 1;
    if (fits) begin
      x_next    = x_r - trial;
      root_next = (root_r >> 1) | mask_r;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      x_r    <= '0;
      root_r <= '0;
      mask_r <= '0;
      cnt_r  <= '0;
      y_bo   <= '0;
      rem_bo <= '0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (start_i) begin
            x_r    <= x_bi;
            root_r <= '0;
            mask_r <= 16'h4000;
            cnt_r  <= '0;
            state  <= WORK;
          end
        end
        WORK: begin
          x_r    <= x_next;
          root_r <= root_next;
          mask_r <= mask_r >> 2;
          cnt_r  <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            y_bo   <= root_next[7:0];
            rem_bo <= x_next[8:0];
            state  <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt16.sv
// Self-checking bench for sqrt16: directed steps with a scoreboard of
// expected roots/remainders checked against an independent search model.
module tb_sqrt16;

  logic        clk_i;
  logic        rst_i;
  logic [15:0] x_bi;
  logic        start_i;
  logic        busy_o;
  logic        ready_o;
  logic [7:0]  y_bo;
  logic [8:0]  rem_bo;

  int total = 0;
  int bad   = 0;

  logic [15:0] q_x[$];
  logic [7:0]  q_y[$];
  logic [8:0]  q_r[$];

  sqrt16 dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .x_bi    (x_bi),
    .start_i (start_i),
    .busy_o  (busy_o),
    .ready_o (ready_o),
    .y_bo    (y_bo),
    .rem_bo  (rem_bo)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Drive a one-cycle start at E0; returns #1 after E0.
  task automatic launch(input logic [15:0] x);
    int r;
    @(negedge clk_i);
    x_bi    = x;
    start_i = 1'b1;
    r = isqrt(int'(x));
    q_x.push_back(x);
    q_y.push_back(r[7:0]);
    q_r.push_back(9'(int'(x) - r * r));
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Wait for ready (bounded), check latency and optionally that old outputs hold.
  task automatic collect(input string tag, input int cyc0, input bit chk_hold,
                         input logic [7:0] old_y, input logic [8:0] old_r);
    int cyc = cyc0;
    int xv, yv;
    while (!ready_o && cyc < 20) begin
      check({tag, "_busy"}, busy_o, 1);
      if (chk_hold) begin
        check({tag, "_hold_y"}, y_bo, old_y);
        check({tag, "_hold_r"}, rem_bo, old_r);
      end
      @(posedge clk_i);
      #1 cyc++;
    end
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_busy_done"}, busy_o, 0);
    if (q_y.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      xv = int'(q_x.pop_front());
      check({tag, "_y"}, y_bo, q_y.pop_front());
      check({tag, "_rem"}, rem_bo, q_r.pop_front());
      yv = int'(y_bo);
      check({tag, "_range"}, ((yv * yv <= xv) && (xv < (yv + 1) * (yv + 1))), 1);
    end
  endtask

  initial begin
    logic [15:0] rx;
    rst_i   = 1'b0;
    start_i = 1'b0;
    x_bi    = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_y", y_bo, 0);
    check("rst_rem", rem_bo, 0);
    rst_i = 1'b1;

    launch(16'd144);
    collect("sq144", 0, 1'b0, '0, '0);

    launch(16'd143);
    collect("x143", 0, 1'b0, '0, '0);
    launch(16'd2);
    check("restart_ready_drop", ready_o, 0);
    collect("x2", 0, 1'b1, 8'd11, 9'd22);

    launch(16'd0);
    collect("x0", 0, 1'b0, '0, '0);
    launch(16'hFFFF);
    collect("xffff", 0, 1'b0, '0, '0);
    launch(16'd65025);
    collect("x65025", 0, 1'b0, '0, '0);

    // Start and operand disturbance during WORK must be ignored
    launch(16'd500);
    repeat (3) begin
      @(negedge clk_i);
      start_i = ~start_i;
      x_bi    = 16'd9999;
    end
    @(negedge clk_i);
    start_i = 1'b0;
    collect("ignore_work", 3, 1'b0, '0, '0);

    // Asynchronous reset mid-computation
    launch(16'd40000);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_ready", ready_o, 0);
    check("arst_y", y_bo, 0);
    check("arst_rem", rem_bo, 0);
    void'(q_x.pop_front());
    void'(q_y.pop_front());
    void'(q_r.pop_front());
    #3 rst_i = 1'b1;
    launch(16'd100);
    collect("after_rst", 0, 1'b0, '0, '0);

    // Chained behind a multiplier holding ready high with product 200*200
    @(negedge clk_i);
    x_bi = 16'd40000;
    repeat (3) @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    q_x.push_back(16'd40000);
    q_y.push_back(8'd200);
    q_r.push_back(9'd0);
    collect("chain", 0, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i);
      #1;
      check("chain_y_stable", y_bo, 200);
      check("chain_rem_stable", rem_bo, 0);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1 check("chain_settle_ready", ready_o, 1);

    for (int i = 0; i < 300; i++) begin
      if (i % 10 == 0) begin
        rx = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
      end else begin
        rx = 16'($urandom_range(0, 65535));
      end
      launch(rx);
      collect("sweep", 0, 1'b0, '0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
